// File: rtl/onehot_mux_pipe_pkg.sv
// Shared constants and the one-hot check helper for the select mux.
// Optional select checking is enabled with the ONEHOT_SEL_CHECK_EN macro.
package mux_pkg;

    localparam int MUX_DEFAULT_WIDTH  = 32;
    localparam int MUX_DEFAULT_NUM_IN = 6;
    localparam int MUX_ERR_CNT_WIDTH  = 8;
    localparam int MUX_MAX_IN         = 64;

    // True when exactly one bit is set; zero-extension keeps this exact.
    function automatic logic is_onehot(input logic [MUX_MAX_IN-1:0] v);
        return (v != '0) && ((v & (v - MUX_MAX_IN'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_mux_comb.sv
// Combinational AND-OR select across NUM_IN channels plus a one-hot flag.
// Purely combinational; no state.
module onehot_mux_comb
    import mux_pkg::*;
#(
    parameter int NUM_IN     = MUX_DEFAULT_NUM_IN,
    parameter int DATA_WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_sel,
    output logic [DATA_WIDTH-1:0]        mux_data,
    output logic                         sel_ok
);

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            mux_data = mux_data
                     | (in_data[k*DATA_WIDTH +: DATA_WIDTH]
                        & {DATA_WIDTH{in_sel[k]}});
        end
        sel_ok = is_onehot(MUX_MAX_IN'(in_sel));
    end

endmodule

// File: rtl/onehot_mux_pipe.sv
// One-hot select mux with valid/ready handshake and two-entry skid buffer.
// ONEHOT_SEL_CHECK_EN drops bad-select beats and counts them.
module onehot_mux_pipe
    import mux_pkg::*;
#(
    parameter int NUM_IN     = MUX_DEFAULT_NUM_IN,
    parameter int DATA_WIDTH = MUX_DEFAULT_WIDTH,
    parameter int CNT_WIDTH  = MUX_ERR_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sel_err,
    output logic [CNT_WIDTH-1:0]         sel_err_cnt
);

    logic [DATA_WIDTH-1:0] mux_data;
    logic                  sel_ok;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  sel_err_q, sel_err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic accept, keep, bad, out_free;

    onehot_mux_comb #(
        .NUM_IN     (NUM_IN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_comb (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .mux_data (mux_data),
        .sel_ok   (sel_ok)
    );

    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

`ifdef ONEHOT_SEL_CHECK_EN
    assign keep = accept && sel_ok;
    assign bad  = accept && !sel_ok;
`else
    logic unused_sel_ok;
    assign unused_sel_ok = sel_ok;
    assign keep = accept;
    assign bad  = 1'b0;
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        sel_err_d    = bad;
        cnt_d        = cnt_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = keep;
                if (keep) out_data_d = mux_data;
            end
        end else if (keep) begin
            skid_valid_d = 1'b1;
            skid_data_d  = mux_data;
        end
        // Saturate rather than wrap so a burst of errors is never hidden.
        if (bad && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            sel_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            sel_err_q    <= sel_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign sel_err     = sel_err_q;
    assign sel_err_cnt = cnt_q;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed self-checking bench for onehot_mux_pipe (NUM_IN=6, W=32, CNT_WIDTH=2).
// Checked-select cases are compiled in when ONEHOT_SEL_CHECK_EN is defined.
module tb_onehot_mux_pipe;

    localparam int NI = 6;
    localparam int W  = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NI*W-1:0] in_data;
    logic [NI-1:0]   in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            sel_err;
    logic [CW-1:0]   sel_err_cnt;

    int total = 0;
    int bad   = 0;

    onehot_mux_pipe #(
        .NUM_IN     (NI),
        .DATA_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sel_err     (sel_err),
        .sel_err_cnt (sel_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NI-1:0] sel, input int ch,
                         input logic [W-1:0] val, input logic v);
        in_data = '0;
        in_data[ch*W +: W] = val;
        in_sel   = sel;
        in_valid = v;
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_sel = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_odata", out_data, 32'd0);
        chk("rst_err", 32'(sel_err), 32'd0);
        chk("rst_cnt", 32'(sel_err_cnt), 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_iready", 32'(in_ready), 32'd1);

        // streaming at full rate
        drive(6'b000100, 2, 32'hDEADBEEF, 1'b1);
        tick();
        chk("s1_valid", 32'(out_valid), 32'd1);
        chk("s1_data", out_data, 32'hDEADBEEF);
        chk("s1_iready", 32'(in_ready), 32'd1);
        drive(6'b100000, 5, 32'h12345678, 1'b1);
        tick();
        chk("s2_valid", 32'(out_valid), 32'd1);
        chk("s2_data", out_data, 32'h12345678);
        chk("s2_iready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("s3_valid", 32'(out_valid), 32'd0);
        chk("s3_hold", out_data, 32'h12345678);

        // backpressure fills output then skid
        out_ready = 1'b0;
        drive(6'b000001, 0, 32'd1, 1'b1);
        tick();
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a_data", out_data, 32'd1);
        chk("bp_a_iready", 32'(in_ready), 32'd1);
        drive(6'b000001, 0, 32'd2, 1'b1);
        tick();
        chk("bp_b_data", out_data, 32'd1);
        chk("bp_b_iready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("bp_hold_data", out_data, 32'd1);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd1);
        chk("bp_drain_data", out_data, 32'd2);
        chk("bp_drain_iready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

`ifdef ONEHOT_SEL_CHECK_EN
        drive(6'b000110, 1, 32'h55, 1'b1);
        tick();
        chk("bad_ovalid", 32'(out_valid), 32'd0);
        chk("bad_err", 32'(sel_err), 32'd1);
        chk("bad_cnt", 32'(sel_err_cnt), 32'd1);
        drive(6'b000001, 0, 32'h77, 1'b1);
        tick();
        chk("good_err", 32'(sel_err), 32'd0);
        chk("good_valid", 32'(out_valid), 32'd1);
        chk("good_data", out_data, 32'h77);
        chk("good_cnt", 32'(sel_err_cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 0, 32'h0, 1'b1);
            tick();
            chk("sat_err", 32'(sel_err), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("sat_cnt", 32'(sel_err_cnt), 32'd3);
        chk("sat_ovalid", 32'(out_valid), 32'd0);
        tick();
        chk("sat_cnt_hold", 32'(sel_err_cnt), 32'd3);
        chk("sat_err_low", 32'(sel_err), 32'd0);
`else
        in_data = '0;
        in_data[0*W +: W] = 32'h0F;
        in_data[1*W +: W] = 32'hF0;
        in_sel = 6'b000011;
        in_valid = 1'b1;
        tick();
        chk("raw_or_valid", 32'(out_valid), 32'd1);
        chk("raw_or_data", out_data, 32'hFF);
        chk("raw_or_err", 32'(sel_err), 32'd0);
        in_sel = 6'b000000;
        tick();
        chk("raw_zero_valid", 32'(out_valid), 32'd1);
        chk("raw_zero_data", out_data, 32'd0);
        chk("raw_zero_err", 32'(sel_err), 32'd0);
        chk("raw_zero_cnt", 32'(sel_err_cnt), 32'd0);
        in_valid = 1'b0;
        tick();
`endif

        // reset while two beats are buffered
        out_ready = 1'b0;
        drive(6'b000001, 0, 32'hAA, 1'b1);
        tick();
        drive(6'b000001, 0, 32'hBB, 1'b1);
        tick();
        chk("mr_full_iready", 32'(in_ready), 32'd0);
        chk("mr_full_data", out_data, 32'hAA);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_ovalid", 32'(out_valid), 32'd0);
        chk("mr_iready", 32'(in_ready), 32'd1);
        chk("mr_cnt", 32'(sel_err_cnt), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_emit", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
